riscv_multicycle_core: RTL
==========================

# riscv_multicycle_core

- Parametrised multi-cycle RISC-V integer core, XLEN selectable (32 or 64).
- Successor to the single-cycle processor: instructions run through a state machine rather than one cycle each.
- A single shared instruction/data memory port with a valid/ready handshake replaces the separate instruction and data memories, so memory latency may vary.
- Exposes debug taps (PC, IR, FSM state, retire pulse, register read port) for bench observation.

## Interface
Parameters:
- XLEN, 64, datapath/register width; legal values 32 or 64.
- RESET_PC, 0, PC value loaded on reset (XLEN bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = store, 0 = read (fetch or load).
- mem_addr  out  XLEN  byte address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- pc_out  out  XLEN  current PC.
- instruction  out  32  instruction register (IR).
- state_out  out  3  FSM state encoding.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky flag: an unsupported opcode/funct was decoded.
- dbg_raddr  in  5  debug register index.
- dbg_rdata  out  XLEN  combinational read of x[dbg_raddr]; x0 reads 0.

## Operation
- Supported instructions:
  - R-type (0110011): add, sub, and, or.
  - addi (0010011, funct3 000).
  - Load (0000011): ld if XLEN=64, lw if XLEN=32.
  - Store (0100011): sd if XLEN=64, sw if XLEN=32.
  - Branch (1100011): beq, bne, blt (signed).
- Any other encoding is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: drive mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: IR<=mem_rdata[31:0], go to DECODE.
- DECODE:
  - Latch A<=x[rs1], B<=x[rs2], IMM<=sign-extended immediate.
  - I/S immediates are 12 bits; the B immediate is a 13-bit byte offset, bit0=0, not rescaled.
  - Illegal encoding: illegal<=1, go to HALT.
- EXEC: ALUOUT<=A op (B or IMM); all arithmetic is modulo 2^XLEN.
  - Branch: pc<=pc+IMM if taken, else pc+4; retire; go to FETCH.
  - Load/store: go to MEM.
  - Otherwise: go to WB.
- MEM: mem_req=1, mem_addr=ALUOUT, mem_we=store, mem_wdata=B.
  - On mem_ready, load: MDR<=mem_rdata, go to WB.
  - On mem_ready, store: pc<=pc+4, retire, go to FETCH.
- WB: x[rd]<=ALUOUT (or MDR for loads); writes to x0 are discarded. pc<=pc+4, retire, go to FETCH.
- HALT: terminal. No mem_req, no register writes. Exit only through reset.
- mem_req, mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
- mem_ready while mem_req=0 is ignored.
- No misalignment checking: mem_addr is driven as computed.

## Timing
- Reset asserted (asynchronous, immediate):
  - state=FETCH, pc=RESET_PC, IR=0, A/B/IMM/ALUOUT/MDR=0, x1..x31=0.
  - illegal=0, retire=0.
  - mem_req=0 while reset is held.
- First fetch request: the first cycle after reset deassertion.
- mem_req, mem_we, mem_addr and mem_wdata are decoded combinationally from the state register.
- Cycles per instruction with zero-wait memory (mem_ready=1 in the request's first cycle):
  - R/I: 4 (FETCH, DECODE, EXEC, WB).
  - Branch: 3.
  - Load: 5.
  - Store: 4.
- Each wait cycle (mem_ready=0) adds one cycle in FETCH or MEM.
- retire is high in the last cycle of the instruction, i.e. the cycle before the return to FETCH.
- Reset mid-instruction (including MEM with a pending request):
  - The instruction is abandoned with no register write.
  - mem_req drops in the same cycle reset asserts.
- Register file: a write in WB is visible to DECODE of the next instruction and to dbg_rdata on the following cycle.

## Structure
- Shared package riscv_pkg holds:
  - Opcode constants.
  - funct3/funct7 constants.
  - State enum (3-bit encoding).
  - ALU operation codes.
- Sub-module regfile_param: XLEN-wide, 32 entries, two read ports plus the debug read port, one synchronous write port, x0 hardwired to 0, asynchronous active-low clear.
- FSM, ALU, immediate generation and the PC are implemented inside the core.

## Test plan
- Zero-wait memory, program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2:
  - Required: x3=12, exactly 3 retire pulses, third pulse at cycle 12 after reset release.
- sub x4,x1,x2 with x1=5, x2=7:
  - XLEN=64: x4=0xFFFF_FFFF_FFFF_FFFE.
  - XLEN=32: x4=0xFFFF_FFFE.
- sd x3,16(x0) then ld x5,16(x0), memory adds 3 wait cycles per access:
  - Request signals stable during waits.
  - x5=12.
  - Store takes 10 cycles, load 11.
- Taken branch: beq x0,x0,-8 at pc=0x20 -> next fetch at 0x18. bne x0,x0 -> next fetch at pc+4. blt with -1 < 1 -> taken.
- Illegal opcode:
  - Fetch 0x0000007F -> illegal=1 and state HALT two cycles later.
  - No further mem_req, no retire.
  - Reset clears illegal.
- Reset asserted during MEM of a pending store:
  - mem_req=0 immediately, no write.
  - After release: pc=RESET_PC, registers all 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V core: opcodes, funct fields,
// FSM state encoding and ALU operation codes.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_W       = 3'b010;
    localparam logic [2:0] F3_D       = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

endpackage

// File: rtl/regfile_param.sv
// 32-entry integer register file: two operand read ports, a debug read port,
// one synchronous write port; x0 is constant zero.
module regfile_param #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [4:0]      raddr_b,
    output logic [XLEN-1:0] rdata_b,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [31:0][XLEN-1:0] regs;

    assign regs[0] = '0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [XLEN-1:0] entry_q;
            logic [XLEN-1:0] entry_d;

            always_comb begin
                entry_d = entry_q;
                if (we && (waddr == 5'(gi))) begin
                    entry_d = wdata;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign regs[gi] = entry_q;
        end
    endgenerate

    assign rdata_a   = regs[raddr_a];
    assign rdata_b   = regs[raddr_b];
    assign dbg_rdata = regs[dbg_raddr];

endmodule

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV integer core sharing one valid/ready memory port between
// instruction fetch and load/store; FSM FETCH-DECODE-EXEC-MEM-WB with HALT.
module riscv_multicycle_core #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     instruction,
    output logic [2:0]      state_out,
    output logic            retire,
    output logic            illegal,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);
    import riscv_pkg::*;

    localparam logic [2:0] F3_MEM = (XLEN == 64) ? F3_D : F3_W;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [XLEN-1:0] aluout_q, aluout_d, mdr_q, mdr_d;
    logic            illegal_q, illegal_d;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic            legal, is_load, is_store, is_branch, use_imm, taken;
    alu_op_e         alu_op;
    logic [XLEN-1:0] imm_gen, alu_b, alu_res, pc_plus4;
    logic [XLEN-1:0] rf_a, rf_b, rf_wdata;
    logic            rf_we;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    always_comb begin
        legal     = 1'b0;
        alu_op    = ALU_ADD;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        use_imm   = 1'b1;
        case (opcode)
            OP_R: begin
                use_imm = 1'b0;
                if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
                    legal = 1'b1;
                end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
                    legal  = 1'b1;
                    alu_op = ALU_SUB;
                end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                    legal  = 1'b1;
                    alu_op = ALU_AND;
                end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
                    legal  = 1'b1;
                    alu_op = ALU_OR;
                end
            end
            OP_IMM:   legal = (funct3 == F3_ADD_SUB);
            OP_LOAD: begin
                is_load = 1'b1;
                legal   = (funct3 == F3_MEM);
            end
            OP_STORE: begin
                is_store = 1'b1;
                legal    = (funct3 == F3_MEM);
            end
            OP_BRANCH: begin
                is_branch = 1'b1;
                legal     = (funct3 == F3_BEQ) || (funct3 == F3_BNE) || (funct3 == F3_BLT);
            end
            default: legal = 1'b0;
        endcase
    end

    // B-type offset keeps its byte granularity: bit0 is a literal zero.
    always_comb begin
        case (opcode)
            OP_STORE:  imm_gen = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BRANCH: imm_gen = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7],
                                  ir_q[30:25], ir_q[11:8], 1'b0};
            default:   imm_gen = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        endcase
    end

    assign alu_b    = use_imm ? imm_q : b_q;
    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            default: alu_res = a_q + alu_b;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_BNE:  taken = (a_q != b_q);
            F3_BLT:  taken = ($signed(a_q) < $signed(b_q));
            default: taken = (a_q == b_q);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        aluout_d  = aluout_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rf_a;
                b_d   = rf_b;
                imm_d = imm_gen;
                if (!legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                aluout_d = alu_res;
                if (is_branch) begin
                    pc_d    = taken ? (pc_q + imm_q) : pc_plus4;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_store) begin
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_d    = pc_plus4;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            aluout_q  <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            aluout_q  <= aluout_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
        end
    end

    // Gating with reset drops the request in the very cycle reset asserts.
    assign mem_req   = reset && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we    = (state_q == S_MEM) && is_store;
    assign mem_addr  = (state_q == S_MEM) ? aluout_q : pc_q;
    assign mem_wdata = (state_q == S_MEM) ? b_q : '0;

    assign retire = (state_q == S_WB)
                 || ((state_q == S_EXEC) && is_branch)
                 || ((state_q == S_MEM) && is_store && mem_ready);

    assign rf_we    = (state_q == S_WB);
    assign rf_wdata = is_load ? mdr_q : aluout_q;

    regfile_param #(.XLEN(XLEN)) u_regfile (
        .clk       (clk),
        .rst_n     (reset),
        .raddr_a   (ir_q[19:15]),
        .rdata_a   (rf_a),
        .raddr_b   (ir_q[24:20]),
        .rdata_b   (rf_b),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .we        (rf_we),
        .waddr     (ir_q[11:7]),
        .wdata     (rf_wdata)
    );

    assign pc_out      = pc_q;
    assign instruction = ir_q;
    assign state_out   = state_q;
    assign illegal     = illegal_q;

endmodule
